// File: rtl/pu_or1k_pfpu32_i2f_pipe.sv
// Integer to IEEE-754 single conversion, 3-stage pipe (sign/magnitude, normalise, round/pack).
// Latency: 3 advancing cycles from a sampled start to i2f_rdy_o.
// Backpressure: adv_i=0 freezes every stage; flush_i drops all in-flight operands.
module pu_or1k_pfpu32_i2f_pipe #(
  parameter int IN_WIDTH = 32  // only 32 and 64 are meaningful
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                adv_i,
  input  logic                start_i,
  input  logic                unsigned_i,
  input  logic [1:0]          rmode_i,
  input  logic [IN_WIDTH-1:0] opa_i,
  output logic                i2f_rdy_o,
  output logic [31:0]         i2f_result_o,
  output logic                i2f_inexact_o
);

  localparam int LZW     = $clog2(IN_WIDTH) + 1;
  localparam int EXP_TOP = 127 + IN_WIDTH - 1;

  // stage 1 state
  logic                s1_vld;
  logic                s1_sign;
  logic [IN_WIDTH-1:0] s1_mag;
  logic [1:0]          s1_rmode;

  // stage 2 state; the normalised leading one is implicit, so only the bits below it are kept
  logic                s2_vld;
  logic                s2_sign;
  logic                s2_zero;
  logic [IN_WIDTH-2:0] s2_norm;
  logic [7:0]          s2_exp;
  logic [1:0]          s2_rmode;

  logic                sign_d;
  logic [IN_WIDTH-1:0] mag_d;
  logic [LZW-1:0]      lzc;
  logic [IN_WIDTH-1:0] norm_d;
  logic [7:0]          exp_d;

  logic [22:0]         mant;
  logic                guard;
  logic                sticky;
  logic                round_up;
  logic [23:0]         mant_rnd;
  logic [7:0]          exp_rnd;
  logic [31:0]         result_d;
  logic                inexact_d;

  // S1 combinational: sign and absolute value; the most negative input maps to 2^(W-1)
  always_comb begin
    sign_d = opa_i[IN_WIDTH-1] & ~unsigned_i;
    mag_d  = sign_d ? (~opa_i + IN_WIDTH'(1)) : opa_i;
  end

  // S2 combinational: leading-zero count (highest set bit wins) and left-normalise
  always_comb begin
    lzc = LZW'(IN_WIDTH);
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (s1_mag[i]) lzc = LZW'(IN_WIDTH - 1 - i);
    end
    norm_d = s1_mag << lzc;
    exp_d  = 8'(EXP_TOP - int'(lzc));
  end

  // S3 combinational: pick mantissa/guard/sticky, apply rounding, pack
  always_comb begin
    mant   = s2_norm[IN_WIDTH-2 -: 23];
    guard  = s2_norm[IN_WIDTH-25];
    sticky = |s2_norm[IN_WIDTH-26:0];
    case (s2_rmode)
      2'b00:   round_up = guard & (sticky | mant[0]);
      2'b01:   round_up = 1'b0;
      2'b10:   round_up = (guard | sticky) & ~s2_sign;
      default: round_up = (guard | sticky) & s2_sign;
    endcase
    // a carry out of the mantissa leaves the low 23 bits zero and bumps the exponent
    mant_rnd  = {1'b0, mant} + 24'(round_up);
    exp_rnd   = s2_exp + 8'(mant_rnd[23]);
    result_d  = s2_zero ? 32'h0 : {s2_sign, exp_rnd, mant_rnd[22:0]};
    inexact_d = ~s2_zero & (guard | sticky);
  end

  // valid chain: flush beats everything, otherwise shift only on advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      i2f_rdy_o <= 1'b0;
    end else if (flush_i) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      i2f_rdy_o <= 1'b0;
    end else if (adv_i) begin
      s1_vld    <= start_i;
      s2_vld    <= s1_vld;
      i2f_rdy_o <= s2_vld;
    end
  end

  // S1 data capture, including the per-operand rounding mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_rmode <= 2'b00;
    end else if (adv_i) begin
      s1_sign  <= sign_d;
      s1_mag   <= mag_d;
      s1_rmode <= rmode_i;
    end
  end

  // S2 data capture; zero magnitude is the only case with no leading one after the shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_norm  <= '0;
      s2_exp   <= 8'h00;
      s2_rmode <= 2'b00;
    end else if (adv_i) begin
      s2_sign  <= s1_sign;
      s2_zero  <= ~norm_d[IN_WIDTH-1];
      s2_norm  <= norm_d[IN_WIDTH-2:0];
      s2_exp   <= exp_d;
      s2_rmode <= s1_rmode;
    end
  end

  // S3 output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i2f_result_o  <= 32'h0;
      i2f_inexact_o <= 1'b0;
    end else if (adv_i) begin
      i2f_result_o  <= result_d;
      i2f_inexact_o <= inexact_d;
    end
  end

endmodule

// File: tb/tb_pu_or1k_pfpu32_i2f_pipe.sv
// Bench for pu_or1k_pfpu32_i2f_pipe: 32- and 64-bit instances driven from one directed sequence,
// expected results queued at the sampling edge and compared when they are due.
module tb_pu_or1k_pfpu32_i2f_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic        inx;
    logic [31:0] due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        adv = 1'b0;
  logic        start32 = 1'b0;
  logic        start64 = 1'b0;
  logic        uns = 1'b0;
  logic [1:0]  rm = 2'b00;
  logic [31:0] opa32 = '0;
  logic [63:0] opa64 = '0;
  logic        rdy32, inx32, rdy64, inx64;
  logic [31:0] res32, res64;

  logic [32:0] cur_e32 = '0;
  logic [32:0] cur_e64 = '0;
  exp_t        q32[$];
  exp_t        q64[$];
  logic [31:0] adv_cnt = '0;
  logic        adv_edge = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  pu_or1k_pfpu32_i2f_pipe #(.IN_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .flush_i(flush), .adv_i(adv), .start_i(start32),
    .unsigned_i(uns), .rmode_i(rm), .opa_i(opa32),
    .i2f_rdy_o(rdy32), .i2f_result_o(res32), .i2f_inexact_o(inx32));

  pu_or1k_pfpu32_i2f_pipe #(.IN_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .flush_i(flush), .adv_i(adv), .start_i(start64),
    .unsigned_i(uns), .rmode_i(rm), .opa_i(opa64),
    .i2f_rdy_o(rdy64), .i2f_result_o(res64), .i2f_inexact_o(inx64));

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference conversion: locate the top bit, shift right, round on the remainder.
  function automatic logic [32:0] model(logic [31:0] a, logic u, logic [1:0] r);
    logic        sgn;
    logic [31:0] m, q, rem, half;
    logic        up;
    logic [7:0]  e;
    int          p;
    sgn = a[31] & ~u;
    m   = sgn ? (~a + 32'd1) : a;
    if (m == 32'd0) return 33'd0;
    p = 31;
    while (m[p] == 1'b0) p--;
    e = 8'(127 + p);
    if (p <= 23) begin
      q = m << (23 - p);
      return {sgn, e, q[22:0], 1'b0};
    end
    q    = m >> (p - 23);
    rem  = m & ((32'd1 << (p - 23)) - 32'd1);
    half = 32'd1 << (p - 24);
    case (r)
      2'b00:   up = (rem > half) || ((rem == half) && q[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = (rem != 0) && !sgn;
      default: up = (rem != 0) && sgn;
    endcase
    q = q + 32'(up);
    if (q[24]) begin
      q = 32'd0;
      e = e + 8'd1;
    end
    return {sgn, e, q[22:0], rem != 32'd0};
  endfunction

  task automatic step(logic s, logic s6, logic a_adv, logic fl, logic [31:0] a, logic [63:0] a6,
                      logic u, logic [1:0] r, logic [32:0] e, logic [32:0] e6);
    start32 = s; start64 = s6; adv = a_adv; flush = fl;
    opa32 = a; opa64 = a6; uns = u; rm = r; cur_e32 = e; cur_e64 = e6;
    @(posedge clk);
    #1;
  endtask

  task automatic v32(logic [31:0] a, logic u, logic [1:0] r, logic [31:0] res, logic inx);
    step(1'b1, 1'b0, 1'b1, 1'b0, a, 64'd0, u, r, {res, inx}, 33'd0);
  endtask

  task automatic rnd32(logic a_adv);
    logic [31:0] a;
    logic        u;
    logic [1:0]  r;
    a = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) a = ~a;
    u = 1'($urandom_range(0, 1));
    r = 2'($urandom_range(0, 3));
    step(1'b1, 1'b0, a_adv, 1'b0, a, 64'd0, u, r, model(a, u, r), 33'd0);
  endtask

  task automatic idle(int n, logic a_adv);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, a_adv, 1'b0, 32'd0, 64'd0, 1'b0, 2'b00, 33'd0, 33'd0);
  endtask

  // scoreboard push: an operand counts only if sampled with adv=1 and no flush
  always @(posedge clk) begin
    if (rst) begin
      q32.delete();
      q64.delete();
      adv_edge = 1'b0;
    end else begin
      if (flush) begin
        q32.delete();
        q64.delete();
      end else if (adv) begin
        if (start32) q32.push_back(exp_t'{cur_e32[32:1], cur_e32[0], adv_cnt + 32'd3});
        if (start64) q64.push_back(exp_t'{cur_e64[32:1], cur_e64[0], adv_cnt + 32'd3});
      end
      if (adv) adv_cnt = adv_cnt + 32'd1;
      adv_edge = adv && !flush;
    end
  end

  // scoreboard pop: after each advancing edge, rdy must be high exactly when a result is due
  always @(negedge clk) begin
    logic d32, d64;
    if (!rst && adv_edge) begin
      d32 = (q32.size() != 0) && (q32[0].due == adv_cnt);
      check("rdy32", 32'(rdy32), 32'(d32));
      if (d32) begin
        if (rdy32) begin
          check("res32", res32, q32[0].res);
          check("inx32", 32'(inx32), 32'(q32[0].inx));
        end
        void'(q32.pop_front());
      end
      d64 = (q64.size() != 0) && (q64[0].due == adv_cnt);
      check("rdy64", 32'(rdy64), 32'(d64));
      if (d64) begin
        if (rdy64) begin
          check("res64", res64, q64[0].res);
          check("inx64", 32'(inx64), 32'(q64[0].inx));
        end
        void'(q64.pop_front());
      end
    end
  end

  initial begin
    // asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #2;
    check("rst_rdy32", 32'(rdy32), 32'd0);
    check("rst_res32", res32, 32'd0);
    check("rst_inx32", 32'(inx32), 32'd0);
    check("rst_rdy64", 32'(rdy64), 32'd0);
    check("rst_res64", res64, 32'd0);
    check("rst_inx64", 32'(inx64), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2, 1'b1);

    // back-to-back directed vectors; first four also feed the 64-bit instance
    step(1, 1, 1, 0, 32'h00000001, 64'h8000000000000000, 0, 2'b00, {32'h3F800000, 1'b0}, {32'hDF000000, 1'b0});
    step(1, 1, 1, 0, 32'hFFFFFFFF, 64'h0000000000000003, 0, 2'b00, {32'hBF800000, 1'b0}, {32'h40400000, 1'b0});
    step(1, 1, 1, 0, 32'h80000000, 64'hFFFFFFFFFFFFFFFF, 0, 2'b00, {32'hCF000000, 1'b0}, {32'hBF800000, 1'b0});
    step(1, 1, 1, 0, 32'h7FFFFFFF, 64'h7FFFFFFFFFFFFFFF, 0, 2'b00, {32'h4F000000, 1'b1}, {32'h5F000000, 1'b1});
    v32(32'h7FFFFFFF, 0, 2'b01, 32'h4EFFFFFF, 1'b1);
    v32(32'h01000001, 0, 2'b00, 32'h4B800000, 1'b1);
    v32(32'h01000001, 0, 2'b10, 32'h4B800001, 1'b1);
    v32(32'h01000001, 0, 2'b11, 32'h4B800000, 1'b1);
    v32(32'hFEFFFFFF, 0, 2'b11, 32'hCB800001, 1'b1);
    v32(32'hFEFFFFFF, 0, 2'b10, 32'hCB800000, 1'b1);
    v32(32'hFFFFFFFF, 1, 2'b00, 32'h4F800000, 1'b1);
    v32(32'h00000000, 1, 2'b10, 32'h00000000, 1'b0);
    v32(32'h00000000, 0, 2'b11, 32'h00000000, 1'b0);
    v32(32'h00000000, 0, 2'b00, 32'h00000000, 1'b0);
    idle(4, 1'b1);

    // starts held on consecutive cycles while adv toggles; only adv=1 cycles sample
    rnd32(1'b1);
    rnd32(1'b0);
    rnd32(1'b1);
    rnd32(1'b0);
    rnd32(1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b0);
      idle(1, 1'b1);
    end

    // flush with two operands in flight, start in the same cycle is dropped
    rnd32(1'b1);
    rnd32(1'b1);
    step(1, 1, 1, 1, 32'h12345678, 64'd5, 0, 2'b00, 33'd0, 33'd0);
    idle(4, 1'b1);
    rnd32(1'b1);
    idle(4, 1'b1);

    // flush while stalled
    rnd32(1'b1);
    step(0, 0, 0, 1, 32'd0, 64'd0, 0, 2'b00, 33'd0, 33'd0);
    idle(4, 1'b1);

    // random stream with random stalls; mode/signedness change every cycle
    for (int i = 0; i < 40; i++) rnd32(1'($urandom_range(0, 3) != 0));
    idle(8, 1'b1);

    // asynchronous reset mid-conversion with a result sitting at the output
    rnd32(1'b1);
    rnd32(1'b1);
    rnd32(1'b1);
    rst = 1'b1;
    #2;
    check("midrst_rdy32", 32'(rdy32), 32'd0);
    check("midrst_res32", res32, 32'd0);
    check("midrst_inx32", 32'(inx32), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(5, 1'b1);
    rnd32(1'b1);
    idle(4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
